// File: rtl/uart_rx_param.sv
// Parametrised UART receiver.
// The rx line is synchronised, the start bit is checked at mid-bit, and the
// data, optional parity and stop bits are sampled once per bit period.
// Each completed frame updates data and the error flags together and raises
// data_valid for one cycle. A frame with a low final stop bit parks the FSM in
// BREAK until the line returns high.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 7,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  // Start-bit check lands H cycles after the first low cycle; the counter
  // starts at 0 on the cycle after it, so it matches at H-1.
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT - 1) / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   parity_bad;
  logic                   stop_bad;
  logic                   tick;
  logic                   stop_low;

  assign rx_s     = sync_reg[SYNC_STAGES-1];
  assign tick     = (cnt == BIT_LAST);
  assign stop_low = stop_bad | ~rx_s;

  // Multi-flop synchroniser on the asynchronous rx pin; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
    end
  end

  // Receive FSM: bit timing, shifting, parity/stop checks and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bad <= 1'b0;
      stop_bad   <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            parity_bad <= 1'b0;
            stop_bad   <= 1'b0;
            if (rx_s) begin
              // Line went back high before mid-bit: a glitch, not a start bit.
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (tick) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_PARITY: begin
          if (tick) begin
            cnt   <= '0;
            state <= S_STOP;
            // Odd parity wants an overall XOR of 1, even parity wants 0.
            parity_bad <= (PARITY == 1) ? ~(^shift_reg ^ rx_s) : (^shift_reg ^ rx_s);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (tick) begin
            cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              data       <= shift_reg;
              data_valid <= 1'b1;
              parity_err <= (PARITY != 0) && parity_bad;
              frame_err  <= stop_low;
              if (stop_low && !rx_s) begin
                // Line is still low after the frame: wait for it to release.
                state <= S_BREAK;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt  <= bit_cnt + BW'(1);
              stop_bad <= stop_low;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four instances cover the default 8N1
// configuration, even parity, odd parity and 7 data bits with 2 stop bits.
module tb_uart_rx_param;

  localparam int C = 7;

  logic       clk;
  logic [3:0] rst_v;
  logic [3:0] rx_v;
  logic [3:0] dv_v, pe_v, fe_v, busy_v;
  logic [7:0] data0, data1, data2;
  logic [6:0] data3;
  logic [31:0] data_w [4];

  int cyc;
  int checks;
  int passed;
  int start_c;

  int          vcount [4];
  int          vcycle [4];
  int          vprev  [4];
  int          wide   [4];
  logic [31:0] vdata  [4];
  logic [31:0] vpdata [4];
  logic [3:0]  dv_last;

  uart_rx_param u_def (
    .clk(clk), .reset(rst_v[0]), .rx(rx_v[0]), .data(data0), .data_valid(dv_v[0]),
    .parity_err(pe_v[0]), .frame_err(fe_v[0]), .busy(busy_v[0])
  );

  uart_rx_param #(.PARITY(2)) u_even (
    .clk(clk), .reset(rst_v[1]), .rx(rx_v[1]), .data(data1), .data_valid(dv_v[1]),
    .parity_err(pe_v[1]), .frame_err(fe_v[1]), .busy(busy_v[1])
  );

  uart_rx_param #(.PARITY(1)) u_odd (
    .clk(clk), .reset(rst_v[2]), .rx(rx_v[2]), .data(data2), .data_valid(dv_v[2]),
    .parity_err(pe_v[2]), .frame_err(fe_v[2]), .busy(busy_v[2])
  );

  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_s2 (
    .clk(clk), .reset(rst_v[3]), .rx(rx_v[3]), .data(data3), .data_valid(dv_v[3]),
    .parity_err(pe_v[3]), .frame_err(fe_v[3]), .busy(busy_v[3])
  );

  assign data_w[0] = 32'(data0);
  assign data_w[1] = 32'(data1);
  assign data_w[2] = 32'(data2);
  assign data_w[3] = 32'(data3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to time strobes.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts pulses, records their cycle and data, flags wide pulses.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (dv_v[d]) begin
        vcount[d] <= vcount[d] + 1;
        vprev[d]  <= vcycle[d];
        vcycle[d] <= cyc;
        vpdata[d] <= vdata[d];
        vdata[d]  <= data_w[d];
        if (dv_last[d]) wide[d] <= wide[d] + 1;
      end
    end
    dv_last <= dv_v;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive n bits LSB first, each held for one bit period.
  task automatic send_bits(input int d, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_v[d] = bits[i];
      repeat (C) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int d, input int nbits);
    rx_v[d] = 1'b1;
    repeat (C * nbits) @(posedge clk);
    #1;
  endtask

  task automatic frame8(input int d, input logic [7:0] v);
    send_bits(d, {6'b0, 1'b1, v, 1'b0}, 10);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc     = 0;
    checks  = 0;
    passed  = 0;
    dv_last = '0;
    for (int d = 0; d < 4; d++) begin
      vcount[d] = 0;
      vcycle[d] = 0;
      vprev[d]  = 0;
      wide[d]   = 0;
      vdata[d]  = '0;
      vpdata[d] = '0;
    end
    rst_v = 4'hF;
    rx_v  = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst_v = 4'h0;
    @(negedge clk);
    chk("reset_data", 32'(data0), 32'h0);
    chk("reset_valid", 32'(dv_v[0]), 32'h0);
    chk("reset_perr", 32'(pe_v[0]), 32'h0);
    chk("reset_ferr", 32'(fe_v[0]), 32'h0);
    chk("reset_busy", 32'(busy_v[0]), 32'h0);
    align();

    // Basic 0x55 frame and its latency from the pin edge.
    start_c = cyc;
    frame8(0, 8'h55);
    idle(0, 2);
    chk("f55_count", 32'(vcount[0]), 32'd1);
    chk("f55_data", 32'(data0), 32'h55);
    chk("f55_perr", 32'(pe_v[0]), 32'h0);
    chk("f55_ferr", 32'(fe_v[0]), 32'h0);
    chk("f55_latency", 32'(vcycle[0] - start_c), 32'd69);
    frame8(0, 8'h55);
    idle(0, 2);
    chk("f55b_count", 32'(vcount[0]), 32'd2);
    chk("f55b_data", 32'(vdata[0]), 32'h55);

    // Back-to-back frames with no idle gap.
    frame8(0, 8'hA3);
    frame8(0, 8'h0F);
    idle(0, 2);
    chk("b2b_count", 32'(vcount[0]), 32'd4);
    chk("b2b_first", vpdata[0], 32'hA3);
    chk("b2b_second", 32'(data0), 32'h0F);
    chk("b2b_spacing", 32'(vcycle[0] - vprev[0]), 32'd70);

    // Two-cycle low glitch rejected at the mid-bit check.
    rx_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_v[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_hi", 32'(busy_v[0]), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_lo", 32'(busy_v[0]), 32'h0);
    align();
    idle(0, 3);
    chk("glitch_count", 32'(vcount[0]), 32'd4);
    chk("glitch_data", 32'(data0), 32'h0F);

    // Framing error followed by a long break.
    send_bits(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
    rx_v[0] = 1'b0;
    repeat (20 * C) @(posedge clk);
    @(negedge clk);
    chk("break_busy", 32'(busy_v[0]), 32'h1);
    chk("break_count", 32'(vcount[0]), 32'd5);
    chk("break_ferr", 32'(fe_v[0]), 32'h1);
    chk("break_data", 32'(data0), 32'h3C);
    align();
    idle(0, 3);
    chk("break_release_count", 32'(vcount[0]), 32'd5);
    chk("break_release_busy", 32'(busy_v[0]), 32'h0);
    frame8(0, 8'h12);
    idle(0, 2);
    chk("recover_count", 32'(vcount[0]), 32'd6);
    chk("recover_ferr", 32'(fe_v[0]), 32'h0);
    chk("recover_data", 32'(data0), 32'h12);

    // Reset in the middle of the data bits.
    send_bits(0, {6'b0, 1'b1, 8'hC6, 1'b0}, 5);
    rst_v[0] = 1'b1;
    rx_v[0]  = 1'b1;
    @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    @(negedge clk);
    chk("midrst_data", 32'(data0), 32'h0);
    chk("midrst_busy", 32'(busy_v[0]), 32'h0);
    chk("midrst_ferr", 32'(fe_v[0]), 32'h0);
    chk("midrst_valid", 32'(dv_v[0]), 32'h0);
    align();
    idle(0, 3);
    chk("midrst_count", 32'(vcount[0]), 32'd6);
    frame8(0, 8'h81);
    idle(0, 2);
    chk("after_rst_count", 32'(vcount[0]), 32'd7);
    chk("after_rst_data", 32'(data0), 32'h81);

    // Even parity: 0xA5 has four ones.
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    idle(1, 2);
    chk("even_ok_count", 32'(vcount[1]), 32'd1);
    chk("even_ok_perr", 32'(pe_v[1]), 32'h0);
    chk("even_ok_data", 32'(data1), 32'hA5);
    send_bits(1, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
    idle(1, 2);
    chk("even_bad_count", 32'(vcount[1]), 32'd2);
    chk("even_bad_perr", 32'(pe_v[1]), 32'h1);
    chk("even_bad_data", 32'(data1), 32'hA5);
    chk("even_bad_ferr", 32'(fe_v[1]), 32'h0);

    // Odd parity on the same word.
    send_bits(2, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
    idle(2, 2);
    chk("odd_ok_count", 32'(vcount[2]), 32'd1);
    chk("odd_ok_perr", 32'(pe_v[2]), 32'h0);
    send_bits(2, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    idle(2, 2);
    chk("odd_bad_perr", 32'(pe_v[2]), 32'h1);
    chk("odd_bad_data", 32'(data2), 32'hA5);

    // 7 data bits, 2 stop bits.
    send_bits(3, {6'b0, 2'b11, 7'h55, 1'b0}, 10);
    idle(3, 2);
    chk("s2_count", 32'(vcount[3]), 32'd1);
    chk("s2_data", 32'(data3), 32'h55);
    chk("s2_ferr", 32'(fe_v[3]), 32'h0);
    send_bits(3, {6'b0, 2'b10, 7'h2A, 1'b0}, 10);
    idle(3, 2);
    chk("s2_bad_stop_ferr", 32'(fe_v[3]), 32'h1);
    chk("s2_bad_stop_data", 32'(data3), 32'h2A);
    chk("s2_bad_stop_busy", 32'(busy_v[3]), 32'h0);
    send_bits(3, {6'b0, 2'b11, 7'h33, 1'b0}, 5);
    rst_v[3] = 1'b1;
    rx_v[3]  = 1'b1;
    @(posedge clk);
    #1;
    rst_v[3] = 1'b0;
    @(negedge clk);
    chk("s2_midrst_data", 32'(data3), 32'h0);
    chk("s2_midrst_ferr", 32'(fe_v[3]), 32'h0);
    chk("s2_midrst_busy", 32'(busy_v[3]), 32'h0);
    align();
    idle(3, 3);
    send_bits(3, {6'b0, 2'b11, 7'h41, 1'b0}, 10);
    idle(3, 2);
    chk("s2_after_rst_count", 32'(vcount[3]), 32'd3);
    chk("s2_after_rst_data", 32'(data3), 32'h41);
    chk("s2_after_rst_ferr", 32'(fe_v[3]), 32'h0);

    for (int d = 0; d < 4; d++) begin
      chk($sformatf("pulse_width_%0d", d), 32'(wide[d]), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1 UART receiver. It deserialises an asynchronous serial line into parallel words using a configurable bit period, data width, parity mode and stop-bit count. The input is synchronised internally, sampled at mid-bit, and glitch-filtered on the start bit. Each frame produces a one-cycle valid strobe with parity and framing status; the block feeds the command/data path behind the board's serial pin.

Parameters:
CLKS_PER_BIT, 7, clk cycles per serial bit; must be >= 4.
DATA_BITS, 8, data bits per frame, range 5..9, LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
SYNC_STAGES, 2, flip-flop synchroniser depth on rx; must be >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
rx  input  1  asynchronous serial line; idle high.
data  output  DATA_BITS  last received word; held until the next frame completes.
data_valid  output  1  one-cycle pulse when a frame completes.
parity_err  output  1  status of the last completed frame; always 0 when PARITY = 0.
frame_err  output  1  status of the last completed frame; set when any stop bit is sampled low.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high, wins over all other activity):
  - data = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - All synchroniser flops = 1. FSM = IDLE. Bit and cycle counters = 0.
- Synchroniser: rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- Timing definitions:
  - H = (CLKS_PER_BIT-1)/2, integer division.
  - N = DATA_BITS + (PARITY != 0) + STOP_BITS.
  - Cycle counter width = clog2(CLKS_PER_BIT).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on the first cycle with rx_s = 0 (cycle t0), go to START and clear the counter.
- START: sample rx_s at t0+H.
  - If rx_s = 1, treat as a glitch: return to IDLE, no strobe, status unchanged.
  - If rx_s = 0, go to DATA.
- Sample schedule: after the start sample, bits are sampled at t0+H+k*CLKS_PER_BIT for k = 1..N. Counter reloads at each sample.
- DATA: shift samples LSB first. After DATA_BITS samples, go to PARITY (if PARITY != 0) or STOP.
- PARITY: compute the parity error against the shifted data.
  - Odd: error if XOR(data, parity bit) = 0.
  - Even: error if XOR(data, parity bit) = 1.
- STOP: sample STOP_BITS bits. Any low sample flags a framing error.
- Completion:
  - Cycle t0+H+N*CLKS_PER_BIT+1: data, parity_err and frame_err update together and data_valid = 1 for exactly that cycle.
  - data is updated even when a framing or parity error is flagged.
  - Errors are not sticky; each completion overwrites them.
- Latency example (defaults C=7, 8N1): data_valid rises 67 cycles after t0, i.e. SYNC_STAGES+67 cycles after the rx pin falls.
- Next frame:
  - If frame_err = 0: return to IDLE the same cycle as the strobe. A start bit beginning immediately after the stop bit is accepted; back-to-back frames need no idle gap.
  - If frame_err = 1 and rx_s = 0 at completion: enter BREAK and stay there, emitting no strobes, until rx_s = 1, then go to IDLE.
- rx changes that occur between samples are ignored.
- Reset mid-frame: abort the frame, apply reset values, no data_valid pulse.

Test Plan:
- Defaults, 10 ns clk, 70 ns bit time: start bit, then 1,0,1,0,1,0,1,0, then stop = 1 → data = 0x55, data_valid pulses exactly once for 1 cycle, parity_err = frame_err = 0. A second identical frame starting at 800 ns → second pulse with data = 0x55.
- Back-to-back frames 0xA3 then 0x0F with zero idle between them → two strobes exactly 10*CLKS_PER_BIT cycles apart, values in order.
- Glitch: rx low for 2 cycles (< H+SYNC_STAGES), then high → no data_valid; busy returns to 0 by t0+H+1; data unchanged.
- PARITY = 2: frame 0xA5 with parity bit 0 → parity_err = 0. Same frame with parity bit 1 → parity_err = 1, data = 0xA5. PARITY = 1 with parity bit 1 → parity_err = 0.
- Framing/break: 0x3C with stop bit = 0, then rx held low for 20 bit times → one strobe with frame_err = 1 and data = 0x3C. No further strobes until rx returns high; a following good 0x12 frame clears frame_err.
- Reset asserted for 1 cycle in the middle of the data bits of a frame → all outputs = 0, no strobe. A later clean 0x81 frame is received correctly. Repeat with STOP_BITS = 2, DATA_BITS = 7.
